// File: rtl/gray_pkg.sv
// Shared types and binary/Gray conversion helpers for gray_conv_pipe.
// Functions work on MAX_W bits; narrower callers zero-extend and truncate.
package gray_pkg;

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } mode_e;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits leave the prefix XOR of the real bits unchanged.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice carrying converted data plus its mode bit.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             mode_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             mode_q;

    // Payload only updates on a real beat, so a bubble leaves old data parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
                mode_q <= mode_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign mode_o  = mode_q;

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined bidirectional binary/Gray converter with valid/ready flow control
// and a wrapping count of delivered output beats.
module gray_conv_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [CNT_W-1:0] beat_cnt,
    input  logic             clr_cnt
);

    logic [WIDTH-1:0]  conv_s;
    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] vld_s;
    logic [WIDTH-1:0]  dat_s  [STAGES];
    logic              mode_s [STAGES];
    logic              ld_chain_s;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Combinational conversion ahead of the first register.
    always_comb begin
        conv_s = '0;
        if (in_mode == MODE_G2B) begin
            conv_s = WIDTH'(gray2bin(MAX_W'(in_data)));
        end else begin
            conv_s = WIDTH'(bin2gray(MAX_W'(in_data)));
        end
    end

    // Load enables ripple back from the consumer: a stage moves if empty or its successor moves.
    always_comb begin
        load_s     = '0;
        ld_chain_s = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld_chain_s = !vld_s[k] || ld_chain_s;
            load_s[k]  = ld_chain_s;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in_s;
        logic [WIDTH-1:0] d_in_s;
        logic             m_in_s;

        if (k == 0) begin : g_first
            assign v_in_s = in_valid;
            assign d_in_s = conv_s;
            assign m_in_s = in_mode;
        end else begin : g_next
            assign v_in_s = vld_s[k-1];
            assign d_in_s = dat_s[k-1];
            assign m_in_s = mode_s[k-1];
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load_s[k]),
            .valid_i (v_in_s),
            .data_i  (d_in_s),
            .mode_i  (m_in_s),
            .valid_o (vld_s[k]),
            .data_o  (dat_s[k]),
            .mode_o  (mode_s[k])
        );
    end

    assign in_ready  = load_s[0];
    assign out_valid = vld_s[STAGES-1];
    assign out_data  = dat_s[STAGES-1];
    assign out_mode  = mode_s[STAGES-1];

    // Clear wins over a coincident increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_cnt = cnt_q;

endmodule
